ser_word_feeder: RTL and testbench

Parallel-to-serial feeder that sits directly upstream of the team's bidirectional shift register. It accepts one WIDTH-bit word per valid/ready handshake and drives the register's serial data, shift-enable and direction inputs. The bit order matches the requested direction, so after the last shift the register's parallel output equals the accepted word. An optional inter-bit gap throttles shift pulses; a one-cycle done pulse marks word completion.

---
 rtl/ser_word_feeder.sv | 174 +++++++++++++++++
 tb/tb_ser_word_feeder.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/ser_word_feeder.sv
// ser_word_feeder
// ---------------
// Parallel-to-serial feeder for the bidirectional shift register. One WIDTH-bit
// word is accepted per valid/ready handshake. It is sent one bit per shift pulse,
// in an order that matches the requested direction. As a result, the downstream
// register holds the original word after the last pulse. GAP idle cycles
// separate consecutive pulses. A one-cycle done pulse follows the last bit.
//
// Optional feature: define SER_PARITY_EN to append one even-parity bit (the XOR
// of the data bits) after the data bits. The downstream register is then
// WIDTH+1 bits wide.
//
// Parameters:
//   WIDTH  data bits per word (>= 2), equal to the downstream register width
//   GAP    idle cycles between consecutive shift pulses (0..15)
//
// Ports:
//   clk       rising-edge clock
//   rstn      synchronous active-low reset
//   in_valid  upstream word valid
//   in_ready  word can be accepted (combinational: IDLE and not in reset)
//   in_data   word to serialize, sampled on accept only
//   in_dir    0 = shift left (MSB first), 1 = shift right (LSB first)
//   sd        serial data bit, meaningful while sen = 1
//   sen       one-cycle shift enable per bit
//   sdir      latched direction for the whole word
//   busy      word in progress
//   done      one-cycle pulse after the last bit

module ser_word_feeder #(
  parameter int WIDTH = 4,
  parameter int GAP   = 0
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_dir,
  output logic             sd,
  output logic             sen,
  output logic             sdir,
  output logic             busy,
  output logic             done
);

`ifdef SER_PARITY_EN
  localparam int NBITS = WIDTH + 1;
`else
  localparam int NBITS = WIDTH;
`endif
  localparam int            CW       = $clog2(NBITS + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(NBITS);
  localparam logic [3:0]    GAP_LAST = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_GAP
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] hold_q;
  logic [CW-1:0]    cnt_q;
  logic [3:0]       gap_q;
  logic             sd_q;
  logic             sen_q;
  logic             sdir_q;
  logic             busy_q;
  logic             done_q;

  logic [CW-1:0]    cnt_d;
  logic             hold_bit;
  logic [WIDTH-1:0] hold_shifted;
  logic             emit_bit;

  // The output registers are loaded on the edge that enters SHIFT, so the
  // pulse and its data bit appear during the SHIFT cycle itself.
  assign cnt_d        = cnt_q + CW'(1);
  assign hold_bit     = sdir_q ? hold_q[0] : hold_q[WIDTH-1];
  assign hold_shifted = sdir_q ? {1'b0, hold_q[WIDTH-1:1]}
                               : {hold_q[WIDTH-2:0], 1'b0};

`ifdef SER_PARITY_EN
  logic          parity_q;
  logic [CW-1:0] emit_idx;

  // Index of the bit about to be emitted. In SHIFT the counter has not yet
  // absorbed the current bit. In GAP it already has.
  assign emit_idx = (state_q == ST_SHIFT) ? cnt_d : cnt_q;
  assign emit_bit = (emit_idx == CW'(WIDTH)) ? parity_q : hold_bit;
`else
  assign emit_bit = hold_bit;
`endif

  assign in_ready = (state_q == ST_IDLE) && rstn;
  assign sd       = sd_q;
  assign sen      = sen_q;
  assign sdir     = sdir_q;
  assign busy     = busy_q;
  assign done     = done_q;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q  <= ST_IDLE;
      hold_q   <= '0;
      cnt_q    <= '0;
      gap_q    <= '0;
      sd_q     <= 1'b0;
      sen_q    <= 1'b0;
      sdir_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef SER_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      sen_q  <= 1'b0;
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            // The first bit leaves straight from the input word. The holding
            // register keeps the remaining bits, already shifted.
            sd_q     <= in_dir ? in_data[0] : in_data[WIDTH-1];
            hold_q   <= in_dir ? {1'b0, in_data[WIDTH-1:1]}
                               : {in_data[WIDTH-2:0], 1'b0};
            sdir_q   <= in_dir;
            cnt_q    <= '0;
            sen_q    <= 1'b1;
            busy_q   <= 1'b1;
            state_q  <= ST_SHIFT;
`ifdef SER_PARITY_EN
            parity_q <= ^in_data;
`endif
          end
        end

        ST_SHIFT: begin
          cnt_q <= cnt_d;
          if (cnt_d == LAST_CNT) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= ST_IDLE;
          end else if (GAP > 0) begin
            gap_q   <= '0;
            state_q <= ST_GAP;
          end else begin
            sd_q    <= emit_bit;
            hold_q  <= hold_shifted;
            sen_q   <= 1'b1;
          end
        end

        ST_GAP: begin
          if (gap_q == GAP_LAST) begin
            sd_q    <= emit_bit;
            hold_q  <= hold_shifted;
            sen_q   <= 1'b1;
            state_q <= ST_SHIFT;
          end else begin
            gap_q   <= gap_q + 4'd1;
          end
        end

        default: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ser_word_feeder.sv
// Testbench for ser_word_feeder. Two instances are used: one with GAP=0 and one
// with GAP=2. Each cycle, every output is compared against a timing model built
// from the word schedule. Bit k of a word accepted at the end of cycle a
// appears in cycle a+1+k*(GAP+1), and done follows one slot after the last bit.
// A model of the downstream shift register is clocked by the DUT's own sen/sd/
// sdir outputs. It must hold the accepted word when done pulses.

module tb_ser_word_feeder;
  localparam int W = 4;
`ifdef SER_PARITY_EN
  localparam int NB = W + 1;
`else
  localparam int NB = W;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rstn;
  logic         in_valid[2];
  logic [W-1:0] in_data[2];
  logic         in_dir[2];
  logic         in_ready[2];
  logic         sd[2];
  logic         sen[2];
  logic         sdir[2];
  logic         busy[2];
  logic         done[2];

  ser_word_feeder #(.WIDTH(W), .GAP(0)) u_g0 (
    .clk(clk), .rstn(rstn), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_data(in_data[0]), .in_dir(in_dir[0]), .sd(sd[0]), .sen(sen[0]),
    .sdir(sdir[0]), .busy(busy[0]), .done(done[0])
  );

  ser_word_feeder #(.WIDTH(W), .GAP(2)) u_g2 (
    .clk(clk), .rstn(rstn), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_data(in_data[1]), .in_dir(in_dir[1]), .sd(sd[1]), .sen(sen[1]),
    .sdir(sdir[1]), .busy(busy[1]), .done(done[1])
  );

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  // Reference model state, per instance.
  int            gapv[2] = '{0, 2};
  bit            act[2];
  int            acc[2];
  logic [W-1:0]  mdat[2];
  logic          mdir[2];
  logic          msdir[2];
  logic [NB-1:0] ds[2];
  bit            accepted[2];

  task automatic chk(input string tag, input int i, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s inst=%0d cycle=%0d observed=%0h expected=%0h",
             tag, i, cyc, obs, exp);
    end
  endtask

  // This is the cycle offset of done relative to the accept cycle.
  function automatic int dlen(input int i);
    return 1 + (NB - 1) * (gapv[i] + 1) + 1;
  endfunction

  function automatic bit m_ready(input int i);
    return (rstn === 1'b1) && (!act[i] || (cyc - acc[i]) >= dlen(i));
  endfunction

  // Each call drives one cycle. The task first checks the combinational ready.
  // It then clocks the edge and advances the model. Finally, it checks all
  // registered outputs of the new cycle.
  task automatic step();
    bit            go[2];
    int            rel;
    int            k;
    bit            sen_e;
    bit            done_e;
    bit            busy_e;
    logic          sd_e;
    logic [NB-1:0] exp_ds;
    #1;
    for (int i = 0; i < 2; i++) begin
      go[i] = m_ready(i);
      chk("in_ready", i, 32'(in_ready[i]), 32'(go[i]));
    end
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      accepted[i] = 1'b0;
      if (rstn !== 1'b1) begin
        act[i]   = 1'b0;
        msdir[i] = 1'b0;
      end else if (in_valid[i] && go[i]) begin
        act[i]      = 1'b1;
        acc[i]      = cyc;
        mdat[i]     = in_data[i];
        mdir[i]     = in_dir[i];
        msdir[i]    = in_dir[i];
        accepted[i] = 1'b1;
        $display("[TB] inst=%0d gap=%0d accept data=%h dir=%0d cycle=%0d",
                 i, gapv[i], in_data[i], in_dir[i], cyc);
      end
    end
    cyc++;
    #1;
    for (int i = 0; i < 2; i++) begin
      rel    = cyc - acc[i];
      k      = (rel - 1) / (gapv[i] + 1);
      sen_e  = act[i] && rel >= 1 && ((rel - 1) % (gapv[i] + 1)) == 0 && k < NB;
      done_e = act[i] && rel == dlen(i);
      busy_e = act[i] && rel >= 1 && rel < dlen(i);
      chk("sen", i, 32'(sen[i]), 32'(sen_e));
      chk("done", i, 32'(done[i]), 32'(done_e));
      chk("busy", i, 32'(busy[i]), 32'(busy_e));
      chk("sdir", i, 32'(sdir[i]), 32'(msdir[i]));
      if (sen_e) begin
        if (k < W) sd_e = mdir[i] ? mdat[i][k] : mdat[i][W-1-k];
        else       sd_e = ^mdat[i];
        chk($sformatf("sd_bit%0d", k), i, 32'(sd[i]), 32'(sd_e));
      end
      if (done_e) begin
`ifdef SER_PARITY_EN
        exp_ds = mdir[i] ? {^mdat[i], mdat[i]} : {mdat[i], ^mdat[i]};
`else
        exp_ds = mdat[i];
`endif
        chk("downstream_word", i, 32'(ds[i]), 32'(exp_ds));
      end
      if (sen[i] === 1'b1)
        ds[i] = sdir[i] ? {sd[i], ds[i][NB-1:1]} : {ds[i][NB-2:0], sd[i]};
    end
  endtask

  task automatic send(input int i, input logic [W-1:0] d, input logic dir);
    int n;
    n           = 0;
    in_valid[i] = 1'b1;
    in_data[i]  = d;
    in_dir[i]   = dir;
    do begin
      step();
      n++;
    end while (!accepted[i] && n < 200);
    if (!accepted[i]) chk("accept_timeout", i, 32'd0, 32'd1);
    in_valid[i] = 1'b0;
    // Inputs are scrambled after acceptance. The serialized word must not
    // follow these changes.
    in_data[i]  = W'($urandom);
    in_dir[i]   = 1'($urandom);
  endtask

  task automatic wait_idle(input int i);
    int n;
    n = 0;
    while (!m_ready(i) && n < 200) begin
      step();
      n++;
    end
    if (!m_ready(i)) chk("idle_timeout", i, 32'd0, 32'd1);
  endtask

  initial begin
    rstn = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid[i] = 1'b0;
      in_data[i]  = '0;
      in_dir[i]   = 1'b0;
      act[i]      = 1'b0;
      acc[i]      = 0;
      mdat[i]     = '0;
      mdir[i]     = 1'b0;
      msdir[i]    = 1'b0;
      ds[i]       = '0;
      accepted[i] = 1'b0;
    end

    // Reset: all outputs low, ready low.
    repeat (3) step();
    rstn = 1'b1;
    step();

    // Directed words on the GAP=0 instance.
    send(0, 4'b1011, 1'b0);
    wait_idle(0);
    send(0, 4'b1011, 1'b1);
    wait_idle(0);

    // Valid is held high across two words, so the second word is accepted
    // in the done cycle.
    send(0, 4'hA, 1'b0);
    send(0, 4'h5, 1'b0);
    wait_idle(0);

    // Inter-bit gap on the GAP=2 instance.
    send(1, 4'b0110, 1'b0);
    wait_idle(1);

    // Reset lands in cycle 2 of a word. The word is aborted, then the next
    // word serializes cleanly.
    send(0, 4'hC, 1'b1);
    step();
    rstn = 1'b0;
    step();
    step();
    rstn = 1'b1;
    step();
    send(0, 4'h3, 1'b0);
    wait_idle(0);

    // Randomized traffic on both instances.
    for (int n = 0; n < 40; n++) begin
      int i;
      i = int'($urandom_range(0, 1));
      repeat ($urandom_range(0, 2)) step();
      send(i, W'($urandom), 1'($urandom));
      if ($urandom_range(0, 2) == 0) wait_idle(i);
    end
    wait_idle(0);
    wait_idle(1);
    repeat (3) step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
